// File: rtl/move_input_conditioner.sv
// Lateral-move button conditioner: sync, debounce, tap latch and press/auto-repeat
// timing, producing direction requests qualified by a periodic move_tick strobe.

module move_dir_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_TICKS    = 6
) (
    input  logic dclk,
    input  logic clr,
    input  logic btn,
    input  logic tick,
    output logic held,
    output logic req
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(REPEAT_TICKS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REPEAT
    } dir_state_t;

    dir_state_t      state, state_next;
    logic [HW-1:0]   hcnt, hcnt_next;
    logic [DW-1:0]   db_cnt;
    logic            s_meta, s_x;
    logic            held_d;
    logic            pend;
    logic            rise;
    logic            p_x;

    assign rise = held & ~held_d;
    assign p_x  = pend | rise;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge dclk) begin
        if (clr) begin
            s_meta <= 1'b0;
            s_x    <= 1'b0;
            db_cnt <= '0;
            held   <= 1'b0;
            held_d <= 1'b0;
            pend   <= 1'b0;
        end else begin
            s_meta <= btn;
            s_x    <= s_meta;
            if (s_x != held) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    held   <= s_x;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            held_d <= held;
            // A tap is remembered until the next tick consumes it.
            pend   <= tick ? 1'b0 : (pend | rise);
        end
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state <= ST_IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_next;
            hcnt  <= hcnt_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        req        = 1'b0;

        if (tick) begin
            if (p_x) begin
                req = 1'b1;
            end else if (state == ST_WAIT) begin
                if (hcnt == HW'(REPEAT_TICKS - 1)) begin
                    req        = 1'b1;
                    state_next = ST_REPEAT;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end else if (state == ST_REPEAT && held) begin
                req = 1'b1;
            end
        end

        // Release overrides any tick-driven progress; pend survives it.
        if (!held) begin
            state_next = ST_IDLE;
            hcnt_next  = '0;
        end else if (state == ST_IDLE && rise) begin
            state_next = ST_WAIT;
            hcnt_next  = '0;
        end
    end

endmodule

module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 1250000,
    parameter int REPEAT_TICKS    = 6
) (
    input  logic dclk,
    input  logic clr,
    input  logic btn_left,
    input  logic btn_right,
    output logic move_tick,
    output logic move_left,
    output logic move_right,
    output logic held_left,
    output logic held_right
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          req_l, req_r;

    assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

    move_dir_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_left (
        .dclk(dclk),
        .clr (clr),
        .btn (btn_left),
        .tick(tick),
        .held(held_left),
        .req (req_l)
    );

    move_dir_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_right (
        .dclk(dclk),
        .clr (clr),
        .btn (btn_right),
        .tick(tick),
        .held(held_right),
        .req (req_r)
    );

    // Opposing requests on the same tick cancel each other.
    always_ff @(posedge dclk) begin
        if (clr) begin
            tick_cnt   <= '0;
            move_tick  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            move_tick <= tick;
            if (tick) begin
                move_left  <= req_l & ~req_r;
                move_right <= req_r & ~req_l;
            end
        end
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE=4, TICK=10, REPEAT=3.

module tb_move_input_conditioner;

    logic dclk = 1'b0;
    logic clr;
    logic btn_left, btn_right;
    logic move_tick, move_left, move_right, held_left, held_right;

    int n_checks = 0;
    int n_fail   = 0;
    int ec       = 0;

    always #5 dclk = ~dclk;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (10),
        .REPEAT_TICKS   (3)
    ) dut (
        .dclk      (dclk),
        .clr       (clr),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .move_tick (move_tick),
        .move_left (move_left),
        .move_right(move_right),
        .held_left (held_left),
        .held_right(held_right)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (ec=%0d): observed %b expected %b", tag, ec, obs, exp);
        end
    endtask

    task automatic adv_to(input int target);
        while (ec < target) begin
            @(posedge dclk);
            #1;
            ec++;
        end
    endtask

    task automatic do_reset(input int n);
        clr = 1'b1;
        repeat (n) begin
            @(posedge dclk);
            #1;
        end
        clr = 1'b0;
        ec  = 0;
    endtask

    task automatic check_moves(input string tag, input logic t, input logic l, input logic r);
        check({tag, "_tick"}, move_tick, t);
        check({tag, "_left"}, move_left, l);
        check({tag, "_right"}, move_right, r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 3 cycles with both buttons pressed
        clr       = 1'b1;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge dclk);
            #1;
            check_moves("rst", 1'b0, 1'b0, 1'b0);
            check("rst_held_l", held_left, 1'b0);
            check("rst_held_r", held_right, 1'b0);
        end
        clr = 1'b0;
        ec  = 0;
        adv_to(5);
        check("pre_held_l", held_left, 1'b0);
        check("pre_held_r", held_right, 1'b0);
        adv_to(6);
        check("post_held_l", held_left, 1'b1);
        check("post_held_r", held_right, 1'b1);
        adv_to(9);
        check("tick_early", move_tick, 1'b0);
        // Both rises share one tick window: conflict cancels
        adv_to(10);
        check_moves("conf_t0", 1'b1, 1'b0, 1'b0);
        adv_to(11);
        check("tick_one_cycle", move_tick, 1'b0);
        adv_to(40);
        check_moves("conf_t3", 1'b1, 1'b0, 1'b0);
        adv_to(50);
        check_moves("conf_t4", 1'b1, 1'b0, 1'b0);

        // Bounce on left: only the final stable edge counts
        btn_left  = 1'b0;
        btn_right = 1'b0;
        do_reset(1);
        btn_left = 1'b1;
        adv_to(2);  btn_left = 1'b0;
        adv_to(4);  btn_left = 1'b1;
        adv_to(6);  btn_left = 1'b0;
        adv_to(8);  btn_left = 1'b1;
        while (ec < 13) begin
            adv_to(ec + 1);
            check("bounce_low", held_left, 1'b0);
        end
        adv_to(14);
        check("bounce_rise", held_left, 1'b1);
        adv_to(20);
        check_moves("bnc_t0", 1'b1, 1'b1, 1'b0);
        adv_to(25);
        check_moves("bnc_hold", 1'b0, 1'b1, 1'b0);
        adv_to(30);
        check_moves("bnc_t1", 1'b1, 1'b0, 1'b0);
        btn_left = 1'b0;
        adv_to(40);
        check_moves("bnc_rel", 1'b1, 1'b0, 1'b0);

        // Tap between ticks: one move at the following tick
        do_reset(1);
        adv_to(15); btn_left = 1'b1;
        adv_to(20);
        check_moves("tap_t_before", 1'b1, 1'b0, 1'b0);
        btn_left = 1'b0;
        adv_to(21);
        check("tap_held", held_left, 1'b1);
        adv_to(26);
        check("tap_released", held_left, 1'b0);
        adv_to(30);
        check_moves("tap_move", 1'b1, 1'b1, 1'b0);
        adv_to(35);
        check_moves("tap_between", 1'b0, 1'b1, 1'b0);
        adv_to(40);
        check_moves("tap_after", 1'b1, 1'b0, 1'b0);

        // Right held 80 cycles: moves at T0, T3.. ; none at T1, T2
        do_reset(1);
        btn_right = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            adv_to(10 * k);
            check_moves($sformatf("hold_T%0d", k - 1), 1'b1, 1'b0,
                        (k == 1) || (k >= 4 && k <= 8));
            if (k == 8) btn_right = 1'b0;
        end

        // Reset while repeating, button kept pressed
        do_reset(1);
        btn_right = 1'b1;
        adv_to(55);
        check("mid_repeat", move_right, 1'b1);
        do_reset(1);
        check_moves("mid_rst", 1'b0, 1'b0, 1'b0);
        check("mid_rst_held", held_right, 1'b0);
        adv_to(5);
        check("mid_pre_held", held_right, 1'b0);
        adv_to(6);
        check("mid_post_held", held_right, 1'b1);
        adv_to(9);
        check_moves("mid_nomove", 1'b0, 1'b0, 1'b0);
        adv_to(10);
        check_moves("mid_T0", 1'b1, 1'b0, 1'b1);
        adv_to(20);
        check_moves("mid_T1", 1'b1, 1'b0, 1'b0);
        adv_to(30);
        check_moves("mid_T2", 1'b1, 1'b0, 1'b0);
        adv_to(40);
        check_moves("mid_T3", 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
